// File: rtl/dcache_2way_wb.sv
// Two-way set-associative write-back, write-allocate data cache with per-set LRU.
// Optional hit/miss counters are enabled by defining DCACHE_2WAY_STATS_EN.
module dcache_2way_wb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
`ifdef DCACHE_2WAY_STATS_EN
    ,
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_miss_o
`endif
);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - BYTE_W;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MISS      = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] REFILL    = 3'd3;
    localparam logic [2:0] REFILLOK  = 3'd4;

    logic [SETS-1:0]   valid_reg [2];
    logic [SETS-1:0]   dirty_reg [2];
    logic [TAG_W-1:0]  tag_reg   [2][SETS];
    logic [LINE_W-1:0] line_reg  [2][SETS];
    logic [SETS-1:0]   lru_reg;
    logic [2:0]        state_reg;
    logic              victim_reg;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic              req;
    logic [1:0]        way_hit;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic [LINE_W-1:0] hit_line;
    logic              unused_bits;

    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx         = p1_addr_i[OFF_W +: IDX_W];
    assign wsel        = p1_addr_i[BYTE_W +: WSEL_W];
    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign unused_bits = ^p1_addr_i[BYTE_W-1:0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[gi][idx] && (tag_reg[gi][idx] == req_tag);
        end
    endgenerate

    assign hit        = req && (|way_hit);
    assign hit_way    = ~way_hit[0];
    assign hit_line   = line_reg[hit_way][idx];
    assign p1_stall_o = req && !hit;
    assign p1_data_o  = (hit && !p1_MemWrite_i) ? hit_line[wsel*DATA_W +: DATA_W] : '0;

    // Fill empty ways before evicting anything.
    always_comb begin
        victim = lru_reg[idx];
        if (!valid_reg[0][idx])
            victim = 1'b0;
        else if (!valid_reg[1][idx])
            victim = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lru_reg <= '0;
            for (int w = 0; w < 2; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
                for (int s = 0; s < SETS; s++) begin
                    tag_reg[w][s]  <= '0;
                    line_reg[w][s] <= '0;
                end
            end
        end else begin
            if (hit) begin
                lru_reg[idx] <= ~hit_way;
                if (p1_MemWrite_i) begin
                    line_reg[hit_way][idx][wsel*DATA_W +: DATA_W] <= p1_data_i;
                    dirty_reg[hit_way][idx] <= 1'b1;
                end
            end
            if (state_reg == REFILL && mem_ack_i) begin
                line_reg[victim_reg][idx]  <= mem_data_i;
                tag_reg[victim_reg][idx]   <= req_tag;
                valid_reg[victim_reg][idx] <= 1'b1;
                dirty_reg[victim_reg][idx] <= 1'b0;
            end
        end
    end

    // Memory outputs are registered so the request first appears in WRITEBACK/REFILL.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            victim_reg   <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !hit) begin
                        state_reg  <= MISS;
                        victim_reg <= victim;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (valid_reg[victim_reg][idx] && dirty_reg[victim_reg][idx]) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {tag_reg[victim_reg][idx], idx, {OFF_W{1'b0}}};
                        mem_data_o  <= line_reg[victim_reg][idx];
                        state_reg   <= WRITEBACK;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
                        mem_data_o  <= '0;
                        state_reg   <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
                        mem_data_o  <= '0;
                        state_reg   <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        mem_addr_o   <= '0;
                        state_reg    <= REFILLOK;
                    end
                end
                REFILLOK: state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_2WAY_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_hit_o  <= '0;
            stat_miss_o <= '0;
        end else if (state_reg == IDLE) begin
            if (hit && stat_hit_o != 32'hFFFF_FFFF)
                stat_hit_o <= stat_hit_o + 32'd1;
            if (req && !hit && stat_miss_o != 32'hFFFF_FFFF)
                stat_miss_o <= stat_miss_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Directed bench for dcache_2way_wb: golden word store, read-data scoreboard, inline memory responder.
module tb_dcache_2way_wb;
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  p1_wdata;
    logic [31:0]  p1_addr;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_enable;
    logic         mem_write;
`ifdef DCACHE_2WAY_STATS_EN
    logic [31:0]  stat_hit;
    logic [31:0]  stat_miss;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0]  exp_q[$];
    txn_t         log_q[$];
    logic [255:0] mem[logic [31:0]];
    logic [31:0]  golden[logic [31:0]];

    always #5 clk = ~clk;

    dcache_2way_wb dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .p1_data_i    (p1_wdata),
        .p1_addr_i    (p1_addr),
        .p1_MemRead_i (p1_rd),
        .p1_MemWrite_i(p1_wr),
        .p1_data_o    (p1_rdata),
        .p1_stall_o   (p1_stall),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack),
        .mem_data_o   (mem_wdata),
        .mem_addr_o   (mem_addr),
        .mem_enable_o (mem_enable),
        .mem_write_o  (mem_write)
`ifdef DCACHE_2WAY_STATS_EN
        ,
        .stat_hit_o   (stat_hit),
        .stat_miss_o  (stat_miss)
`endif
    );

    function automatic logic [255:0] dflt_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'hC0DE_0000;
        return l;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        if (mem.exists(la))
            return mem[la];
        return dflt_line(la);
    endfunction

    function automatic logic [31:0] gword(input logic [31:0] a);
        logic [31:0]  wa;
        logic [255:0] l;
        wa = {a[31:2], 2'b00};
        if (golden.exists(wa))
            return golden[wa];
        l = dflt_line({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    function automatic txn_t get_log(input int i);
        txn_t t;
        t.wr = 1'b0;
        t.addr = 32'hFFFF_FFFF;
        t.data = '1;
        if (i < log_q.size())
            t = log_q[i];
        return t;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns how many sampled cycles showed stall.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, output int stalls);
        bit done;
        stalls = 0;
        done = 0;
        log_q.delete();
        p1_addr = a;
        p1_wdata = wd;
        p1_wr = wr;
        p1_rd = !wr;
        if (!wr)
            exp_q.push_back(gword(a));
        else
            golden[{a[31:2], 2'b00}] = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!p1_stall) begin
                if (!wr) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("rdata", {224'b0, p1_rdata}, {224'b0, e});
                end
                done = 1;
            end else begin
                stalls++;
                if (mem_enable) begin
                    log_q.push_back('{mem_write, mem_addr, mem_wdata});
                    if (mem_write)
                        mem[mem_addr] = mem_wdata;
                    else
                        mem_rdata = get_line(mem_addr);
                    mem_ack = 1'b1;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check("complete", {255'b0, done}, 256'd1);
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        $display("[TB] %s addr=%08h wdata=%08h rdata=%08h stalls=%0d memtxn=%0d",
                 wr ? "ST" : "LD", a, wd, p1_rdata, stalls, log_q.size());
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int st;
        txn_t t;
        logic [255:0] l;
        rst_n = 1'b0;
        p1_wdata = '0;
        p1_addr = '0;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        l = dflt_line(32'h40);
        l[63:32] = 32'hA5A5_A5A5;
        mem[32'h40] = l;
        golden[32'h44] = 32'hA5A5_A5A5;
        #1;
        check("rst_enable", {255'b0, mem_enable}, 256'd0);
        check("rst_stall", {255'b0, p1_stall}, 256'd0);
        check("rst_rdata", {224'b0, p1_rdata}, 256'd0);
        check("rst_addr", {224'b0, mem_addr}, 256'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean miss then refill
        access(0, 32'h44, 0, st);
        check("c1_stalls", st, 3);
        t = get_log(0);
        check("c1_nlog", log_q.size(), 1);
        check("c1_wr", {255'b0, t.wr}, 256'd0);
        check("c1_addr", {224'b0, t.addr}, 256'h40);

        // Store hit, then read back
        access(1, 32'h44, 32'h1234_5678, st);
        check("c2_st_stalls", st, 0);
        check("c2_st_nlog", log_q.size(), 0);
        access(0, 32'h44, 0, st);
        check("c2_ld_stalls", st, 0);

        // Dirty 0x44 is dropped by reset
        pulse_reset();
        golden[32'h44] = 32'hA5A5_A5A5;
`ifdef DCACHE_2WAY_STATS_EN
        #1;
        check("stat_rst_hit", {224'b0, stat_hit}, 256'd0);
`endif

        // Fill both ways of set 2, then evict the LRU way
        access(0, 32'h40, 0, st);
        check("c3_a_stalls", st, 3);
        t = get_log(0);
        check("c3_a_addr", {224'b0, t.addr}, 256'h40);
        access(0, 32'h440, 0, st);
        check("c3_b_stalls", st, 3);
        t = get_log(0);
        check("c3_b_nlog", log_q.size(), 1);
        check("c3_b_wr", {255'b0, t.wr}, 256'd0);
        check("c3_b_addr", {224'b0, t.addr}, 256'h440);
        access(0, 32'h40, 0, st);
        check("c3_c_stalls", st, 0);
        access(0, 32'h840, 0, st);
        check("c3_d_stalls", st, 3);
        t = get_log(0);
        check("c3_d_nlog", log_q.size(), 1);
        check("c3_d_addr", {224'b0, t.addr}, 256'h840);
`ifdef DCACHE_2WAY_STATS_EN
        check("stat_miss", {224'b0, stat_miss}, 256'd3);
        check("stat_hit", {224'b0, stat_hit}, 256'd1);
`endif
        access(0, 32'h40, 0, st);
        check("c3_e_stalls", st, 0);

        // Dirty eviction
        access(1, 32'h40, 32'hDEAD_BEEF, st);
        check("c4_st_stalls", st, 0);
        access(0, 32'h440, 0, st);
        check("c4_a_stalls", st, 3);
        check("c4_a_nlog", log_q.size(), 1);
        access(0, 32'h840, 0, st);
        check("c4_b_stalls", st, 4);
        check("c4_b_nlog", log_q.size(), 2);
        t = get_log(0);
        l = dflt_line(32'h40);
        l[63:32] = 32'hA5A5_A5A5;
        l[31:0] = 32'hDEAD_BEEF;
        check("c4_wb_wr", {255'b0, t.wr}, 256'd1);
        check("c4_wb_addr", {224'b0, t.addr}, 256'h40);
        check("c4_wb_data", t.data, l);
        t = get_log(1);
        check("c4_rf_wr", {255'b0, t.wr}, 256'd0);
        check("c4_rf_addr", {224'b0, t.addr}, 256'h840);
        access(0, 32'h40, 0, st);
        check("c4_reload_stalls", st, 3);

        // Reset while a refill is outstanding
        p1_addr = 32'h1000;
        p1_rd = 1'b1;
        for (int c = 0; c < 10 && !mem_enable; c++)
            @(negedge clk);
        #1;
        check("c5_enable_seen", {255'b0, mem_enable}, 256'd1);
        rst_n = 1'b0;
        p1_rd = 1'b0;
        #1;
        check("c5_enable", {255'b0, mem_enable}, 256'd0);
        check("c5_write", {255'b0, mem_write}, 256'd0);
        check("c5_addr", {224'b0, mem_addr}, 256'd0);
        check("c5_wdata", mem_wdata, 256'd0);
        check("c5_stall", {255'b0, p1_stall}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 32'h1000, 0, st);
        check("c5_remiss_stalls", st, 3);
        access(0, 32'h40, 0, st);
        check("c5_cold_stalls", st, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dcache_2way_wb.md
Name: dcache_2way_wb

Overview:
Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU load/store port and the line-wide data memory. It is the next generation of the direct-mapped data cache: configurable geometry, per-set LRU replacement, invalid-way-first victim choice and flop-based tag/data storage held inside the block.
A hit completes in the request cycle with no stall. A miss stalls the CPU while the cache writes back a dirty victim, if there is one, and then refills the line.

Parameters:
ADDR_W, 32, CPU/memory byte-address width
DATA_W, 32, CPU word width (power of 2, >=8)
LINE_W, 256, cache line width in bits; must equal the memory data width and be a multiple of DATA_W
SETS, 32, number of sets (power of 2, >=2); index bits IDX_W=log2(SETS)

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  reset, asynchronous, active-low
p1_data_i  in  DATA_W  store data
p1_addr_i  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request; takes priority if both request inputs are high
p1_data_o  out  DATA_W  load data, valid while a read hits
p1_stall_o  out  1  high while a request is pending and not yet a hit
mem_data_i  in  LINE_W  refill line
mem_ack_i  in  1  one-cycle completion pulse from memory
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned address (offset bits zero)
mem_enable_o  out  1  memory request, held until mem_ack_i
mem_write_o  out  1  1 = write-back, 0 = refill read

Behaviour:
- Address split: OFF_W = log2(LINE_W/8) offset bits, IDX_W index bits, tag = the remaining upper bits. Word select = addr[OFF_W-1 : log2(DATA_W/8)].
- Per way and set: valid, dirty, tag, line. Per set: one lru bit naming the least-recently-used way. All of these are reset to 0.
- Hit: req & valid & tag-match in either way, evaluated combinationally.
  - p1_stall_o = req & ~hit.
  - p1_data_o = the selected word of the hit way; it is 0 when there is no read hit.
- Store hit: on the clock edge, the selected word is written, dirty is set to 1, and lru points to the other way.
- Load hit: lru points to the other way on the edge.
- Victim choice: invalid way0 first, then invalid way1, else the way named by lru. The victim is latched when entering MISS.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILLOK.
  - IDLE: req & ~hit -> MISS.
  - MISS:
    - Victim valid & dirty: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line; go to WRITEBACK.
    - Otherwise: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 0}; go to REFILL.
  - WRITEBACK: stay until mem_ack_i. Then switch to the refill read (mem_write_o=0, new address, mem_enable_o stays 1) and go to REFILL.
  - REFILL: on mem_ack_i, write mem_data_i into the victim way with valid=1, dirty=0, tag = req tag. Drop mem_enable_o and go to REFILLOK.
  - REFILLOK: a one-cycle bubble, then IDLE. The request now hits; a store hit merges its word and sets dirty the normal way.
- Latency:
  - Clean miss: stall for 3 cycles plus the memory wait.
  - Dirty miss: one extra memory round trip.
- Request inputs must stay stable while p1_stall_o=1. Behaviour is undefined if they change.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- mem_ack_i in the same cycle as mem_enable_o first rises is accepted.
- Reset (asynchronous, any state including mid-transfer):
  - State returns to IDLE.
  - All memory outputs go to 0; mem_data_o/mem_addr_o are 0 in IDLE.
  - All valid/dirty/lru bits are cleared; no write-back of lost dirty data.
- Requests with no request input high change no state.

Optional Feature:
DCACHE_2WAY_STATS_EN.
- Defined: adds outputs stat_hit_o and stat_miss_o (32-bit each), both reset to 0.
  - stat_hit_o increments on each hit cycle in IDLE, excluding the REFILLOK re-hit.
  - stat_miss_o increments on each IDLE->MISS transition.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
All cases use default parameters: tag = addr[31:10], index = addr[9:5].
- Reset, then load 0x00000044:
  - stall=1; MISS, then mem_enable_o=1, mem_write_o=0, mem_addr_o=0x00000040.
  - Ack with a line whose word1 is 0xA5A5A5A5 -> after REFILLOK, stall=0 and p1_data_o=0xA5A5A5A5.
- Store 0x12345678 to 0x00000044 after the previous case:
  - no stall, no memory traffic.
  - A following load of 0x44 returns 0x12345678.
- Fill both ways of set 2 by loading 0x00000040 then 0x00000440: two refills, no write-back.
  - Load 0x40 again to make way1 the LRU.
  - Load 0x00000840 -> evicts the 0x440 line; a later load of 0x40 still hits.
- Dirty eviction:
  - Store to 0x00000040, then load 0x00000440.
  - Load 0x00000840 with lru on the dirty way.
  - Required: mem_write_o=1, mem_addr_o=0x00000040, mem_data_o holds the stored word; after the ack, a refill read of 0x00000840.
- Assert rst_i=0 while in REFILL with mem_enable_o=1:
  - outputs go to 0 immediately; stall drops if no request.
  - After release, the same load misses again.
- With DCACHE_2WAY_STATS_EN, run case 3: stat_miss_o=3, stat_hit_o=1.
